spi_slave_param: RTL and testbench
==================================

// Module: spi_slave_param
// PURPOSE
//  Parametrised SPI slave, successor to the fixed 8-bit slave in the SPI/RAM wrapper.
//  Deserialises a (DATA_W+2)-bit MOSI frame {cmd[1:0], payload[DATA_W-1:0]} to the RAM side.
//  For read-data frames it serialises DATA_W bits of RAM tx_data onto MISO.
//  Adds selectable bit order, a tx_valid timeout, frame-abort detection and a read-address guard.
// PARAMETERS
//  DATA_W     8   payload/tx width; frame length FRAME_W = DATA_W+2
//  LSB_FIRST  0   0: MSB of frame/tx word first; 1: LSB first (whole word incl. cmd)
//  TIMEOUT    16  max cycles in WAIT_TX for tx_valid before abort (>=1)
// PORTS
//  clk        in   1         system clock, also SPI bit clock; all sampling on posedge
//  rst        in   1         asynchronous, active-high reset
//  SS_n       in   1         slave select, active low
//  MOSI       in   1         serial data in, sampled on posedge
//  MISO       out  1         serial data out, registered, updates on posedge
//  rx_data    out  DATA_W+2  received frame {cmd, payload}, held until next rx_valid
//  rx_valid   out  1         1-cycle pulse: rx_data holds a new frame
//  tx_data    in   DATA_W    read data from RAM
//  tx_valid   in   1         tx_data valid; honoured only in WAIT_TX
//  frame_err  out  1         1-cycle pulse on abort/timeout/guard violation
//  busy       out  1         high whenever state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; MISO, rx_valid, frame_err, busy = 0; rx_data = 0; rd_addr_ok flag = 0.
//    Reset mid-frame takes effect immediately; no rx_valid/frame_err is generated.
//  cmd: 00 write addr, 01 write data, 10 read addr, 11 read data.
//  States: IDLE, RX, WAIT_TX, SEND, DONE.
//  IDLE: first posedge with SS_n=0 captures MOSI as frame bit 0 -> RX, bit_cnt=1.
//  RX: capture one bit per posedge; after the posedge that captures bit FRAME_W-1:
//    cmd 00/01/10 -> rx_valid pulse next cycle, rx_data updated same edge -> DONE; cmd 10 sets rd_addr_ok.
//    cmd 11 & rd_addr_ok -> rx_valid pulse -> WAIT_TX, wait_cnt=0.
//    cmd 11 & !rd_addr_ok -> frame_err pulse, no rx_valid, rx_data unchanged -> DONE.
//  WAIT_TX: tx_valid sampled high -> latch tx_data -> SEND; first MISO bit driven at the same edge.
//    wait_cnt reaches TIMEOUT without tx_valid -> frame_err pulse -> DONE.
//  SEND: one MISO bit per posedge, DATA_W bits total (master samples on negedge);
//    after last bit: MISO=0, rd_addr_ok cleared -> DONE.
//  DONE: extra MOSI bits ignored, MISO=0; SS_n=1 -> IDLE.
//  SS_n=1 in RX/WAIT_TX/SEND -> abort: frame_err pulse, MISO=0 -> IDLE;
//    no rx_valid; rd_addr_ok unchanged.
//  Back-to-back frames need >=1 sampled SS_n=1 cycle between them.
//  tx_valid outside WAIT_TX is ignored; tx_valid and SS_n rise on the same edge -> abort wins.
//  bit_cnt width $clog2(FRAME_W+1); wait_cnt width $clog2(TIMEOUT+1); neither wraps.
// STRUCTURE
//  spi_slave_pkg: state enum, cmd codes (CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA).
//  Sub-module spi_tx_shifter (load, shift enable, LSB_FIRST, DATA_W) produces MISO.
//  Receive shifter, counters and FSM live in spi_slave_param.
// TESTING (DATA_W=8, TIMEOUT=16 unless stated)
//  1. MSB-first frame 10'h1FF (cmd 01) -> one rx_valid pulse, rx_data=10'h1FF, MISO stays 0, frame_err 0.
//  2. Frame 10'h205 (cmd 10), then frame 10'h300, tx_valid+tx_data=8'hA5 two cycles after rx_valid
//     -> MISO 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0.
//  3. SS_n high after 6 bits -> frame_err pulse, no rx_valid; next full frame 10'h0AB -> rx_data=10'h0AB.
//  4. cmd 10 then cmd 11, tx_valid withheld 20 cycles -> frame_err on 16th wait cycle, MISO 0, DONE until SS_n=1.
//  5. LSB_FIRST=1: send 10'h2C3 LSB first -> rx_data=10'h2C3; tx 8'h0F -> MISO 1,1,1,1,0,0,0,0.
//  6. rst=1 mid-SEND -> MISO/rx_valid/busy 0 at once;
//     after release, cmd 11 frame -> frame_err pulse, no rx_valid.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the parametrised SPI slave.
//   state_e     : FSM states of spi_slave_param
//   cmd_t       : 2-bit command field carried in the top bits of every frame
//   frame_w()   : frame length (command + payload) for a given payload width
package spi_slave_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRx,
        StWaitTx,
        StSend,
        StDone
    } state_e;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_WR_ADDR = 2'b00;
    localparam cmd_t CMD_WR_DATA = 2'b01;
    localparam cmd_t CMD_RD_ADDR = 2'b10;
    localparam cmd_t CMD_RD_DATA = 2'b11;

    function automatic int unsigned frame_w(input int unsigned data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// Bus bundle between an SPI master / RAM side and spi_slave_param.
//   SS_n, MOSI           : serial link from the master
//   MISO                 : serial read data back to the master
//   rx_data, rx_valid    : received frame {cmd, payload} towards the RAM
//   tx_data, tx_valid    : read data from the RAM
//   frame_err, busy      : status
// Modport slave is the DUT view, master is the driving side.
interface spi_slave_param_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, frame_err, busy
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, frame_err, busy
    );

endinterface

// File: rtl/spi_tx_shifter.sv
// MISO serialiser for read-data frames.
//   clk, rst : system clock, asynchronous active-high reset
//   load     : capture data and drive its first bit on MISO at the same edge
//   shift    : drive the next bit
//   clear    : force MISO low (idle / end of word / abort)
//   data     : word to serialise
//   miso     : registered serial output
// Bit order follows LSB_FIRST. Priority: clear, load, shift.
module spi_tx_shifter #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic              miso
);

    // sh_q holds the bits not yet presented, next bit at the outgoing end.
    logic [DATA_W-1:0] sh_q;
    logic              miso_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            miso_q <= 1'b0;
        end else if (clear) begin
            sh_q   <= '0;
            miso_q <= 1'b0;
        end else if (load) begin
            if (LSB_FIRST) begin
                miso_q <= data[0];
                sh_q   <= data >> 1;
            end else begin
                miso_q <= data[DATA_W-1];
                sh_q   <= data << 1;
            end
        end else if (shift) begin
            if (LSB_FIRST) begin
                miso_q <= sh_q[0];
                sh_q   <= sh_q >> 1;
            end else begin
                miso_q <= sh_q[DATA_W-1];
                sh_q   <= sh_q << 1;
            end
        end
    end

    assign miso = miso_q;

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave. SPI bit clock is the system clock; everything samples on posedge.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : spi_slave_param_if slave modport
//              SS_n/MOSI in, MISO out (registered), rx_data/rx_valid to RAM,
//              tx_data/tx_valid from RAM, frame_err pulse, busy (state != idle)
// A frame is DATA_W+2 bits {cmd, payload}. Read-data frames (cmd 11) are only
// served after a read-address frame; the reply word is then shifted out on MISO.
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b0,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    spi_slave_param_if.slave    bus
);

    localparam int unsigned FRAME_W = frame_w(DATA_W);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  LAST_RX_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]  LAST_TX_BIT = CNT_W'(DATA_W);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_FULL   = WAIT_W'(TIMEOUT);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [FRAME_W-1:0]   rx_shift_q, rx_shift_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rd_addr_ok_q, rd_addr_ok_d;

    logic                 tx_load, tx_shift, tx_clear;
    logic                 miso;
    logic [FRAME_W-1:0]   rx_shift_in;
    cmd_t                 frame_cmd;

    // Shift register with this edge's MOSI bit included; after the last bit it
    // holds the frame in natural order regardless of bit order on the wire.
    always_comb begin
        if (LSB_FIRST) begin
            rx_shift_in = {bus.MOSI, rx_shift_q[FRAME_W-1:1]};
        end else begin
            rx_shift_in = {rx_shift_q[FRAME_W-2:0], bus.MOSI};
        end
    end

    assign frame_cmd = cmd_t'(rx_shift_in[FRAME_W-1 -: 2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_addr_ok_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            rd_addr_ok_q <= rd_addr_ok_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        rd_addr_ok_d = rd_addr_ok_q;
        tx_load      = 1'b0;
        tx_shift     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!bus.SS_n) begin
                    rx_shift_d = rx_shift_in;
                    bit_cnt_d  = CNT_W'(1);
                    state_d    = StRx;
                end
            end

            StRx: begin
                if (bus.SS_n) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    rx_shift_d = rx_shift_in;
                    if (bit_cnt_q == LAST_RX_BIT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (frame_cmd == CMD_RD_DATA) begin
                            if (rd_addr_ok_q) begin
                                rx_data_d  = rx_shift_in;
                                rx_valid_d = 1'b1;
                                wait_cnt_d = '0;
                                state_d    = StWaitTx;
                            end else begin
                                // Read without a prior address: reject, keep old rx_data.
                                frame_err_d = 1'b1;
                                state_d     = StDone;
                            end
                        end else begin
                            rx_data_d  = rx_shift_in;
                            rx_valid_d = 1'b1;
                            state_d    = StDone;
                            if (frame_cmd == CMD_RD_ADDR) begin
                                rd_addr_ok_d = 1'b1;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end

            StWaitTx: begin
                if (bus.SS_n) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else if (bus.tx_valid) begin
                    tx_load   = 1'b1;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = StSend;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d  = WAIT_FULL;
                    frame_err_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            StSend: begin
                if (bus.SS_n) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else if (bit_cnt_q == LAST_TX_BIT) begin
                    // Last bit has had its full cycle on MISO; the read is consumed.
                    rd_addr_ok_d = 1'b0;
                    state_d      = StDone;
                end else begin
                    tx_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            StDone: begin
                if (bus.SS_n) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // MISO is only ever non-zero while a word is being loaded or shifted.
    assign tx_clear = !(tx_load || tx_shift);

    spi_tx_shifter #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_tx_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (tx_load),
        .shift (tx_shift),
        .clear (tx_clear),
        .data  (bus.tx_data),
        .miso  (miso)
    );

    assign bus.MISO      = miso;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: one MSB-first and one LSB-first instance, driven one at a time.
module tb_spi_slave_param;

    localparam int DW = 8;
    localparam int FW = DW + 2;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       ss_n, mosi, tx_valid;
    logic [7:0] tx_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_slave_param_if #(.DATA_W(DW)) if0 ();
    spi_slave_param_if #(.DATA_W(DW)) if1 ();

    assign if0.SS_n     = sel ? 1'b1 : ss_n;
    assign if0.MOSI     = mosi;
    assign if0.tx_data  = tx_data;
    assign if0.tx_valid = !sel && tx_valid;
    assign if1.SS_n     = sel ? ss_n : 1'b1;
    assign if1.MOSI     = mosi;
    assign if1.tx_data  = tx_data;
    assign if1.tx_valid = sel && tx_valid;

    spi_slave_param #(.DATA_W(DW), .LSB_FIRST(1'b0), .TIMEOUT(TO)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    spi_slave_param #(.DATA_W(DW), .LSB_FIRST(1'b1), .TIMEOUT(TO)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    logic          miso_m, rv_m, err_m, busy_m;
    logic [FW-1:0] rx_m;
    assign miso_m = sel ? if1.MISO      : if0.MISO;
    assign rv_m   = sel ? if1.rx_valid  : if0.rx_valid;
    assign err_m  = sel ? if1.frame_err : if0.frame_err;
    assign busy_m = sel ? if1.busy      : if0.busy;
    assign rx_m   = sel ? if1.rx_data   : if0.rx_data;

    // Reference model state, per instance.
    logic          m_ok [2];
    logic [FW-1:0] m_rx [2];

    typedef struct {
        logic          sel;
        logic [FW-1:0] frame;
        int            nbits;
        int            hold;
        int            tx_at;
        logic [7:0]    txd;
        int            rv_at;
        int            err_at;
        int            miso_at;
        int            miso_len;
        logic [FW-1:0] rx_exp;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic d, input logic tv);
        ss_n     = s;
        mosi     = d;
        tx_valid = tv;
        @(posedge clk);
        #1;
    endtask

    // Frame-level expectations derived from the protocol rules. Cycle index i is the
    // observation just after the i-th posedge of the frame; bit k is captured at edge k.
    task automatic model(input logic s, input logic [FW-1:0] fr, input int nb, input int hold,
                         input int tx_at, output int rv_at, output int err_at,
                         output int miso_at, output int miso_len, output logic [FW-1:0] rx_exp);
        int si;
        si       = s ? 1 : 0;
        rv_at    = -1;
        err_at   = -1;
        miso_at  = -1;
        miso_len = 0;
        if (nb < FW) begin
            err_at = nb;
        end else if (fr[FW-1:FW-2] != 2'b11) begin
            rv_at    = FW - 1;
            m_rx[si] = fr;
            if (fr[FW-1:FW-2] == 2'b10) m_ok[si] = 1'b1;
        end else if (!m_ok[si]) begin
            err_at = FW - 1;
        end else begin
            rv_at    = FW - 1;
            m_rx[si] = fr;
            if (tx_at >= 0 && tx_at < hold && tx_at < TO) begin
                miso_at = FW + tx_at;
                if (hold >= tx_at + DW + 1) begin
                    miso_len = DW;
                    m_ok[si] = 1'b0;
                end else begin
                    miso_len = hold - tx_at;
                    err_at   = FW + hold;
                end
            end else if (hold >= TO) begin
                err_at = FW + TO - 1;
            end else begin
                err_at = FW + hold;
            end
        end
        rx_exp = m_rx[si];
    endtask

    task automatic run_frame(input logic s, input logic [FW-1:0] fr, input int nb,
                             input int hold, input int tx_at, input logic [7:0] txd,
                             input int rv_at, input int err_at, input int miso_at,
                             input int miso_len, input logic [FW-1:0] rx_exp, input string nm);
        logic [63:0] rv_tr, err_tr, miso_tr, e_rv, e_err, e_miso;
        logic        busy_low;
        int          idx;
        rv_tr   = '0;
        err_tr  = '0;
        miso_tr = '0;
        idx     = 0;
        sel     = s;
        tx_data = txd;
        for (int b = 0; b < nb; b++) begin
            cyc(1'b0, s ? fr[b] : fr[FW-1-b], 1'b0);
            rv_tr[idx] = rv_m; err_tr[idx] = err_m; miso_tr[idx] = miso_m; idx++;
        end
        if (nb == FW) begin
            for (int j = 0; j < hold; j++) begin
                cyc(1'b0, 1'b0, j == tx_at);
                rv_tr[idx] = rv_m; err_tr[idx] = err_m; miso_tr[idx] = miso_m; idx++;
            end
        end
        busy_low = busy_m;
        for (int g = 0; g < 2; g++) begin
            cyc(1'b1, 1'b0, 1'b0);
            rv_tr[idx] = rv_m; err_tr[idx] = err_m; miso_tr[idx] = miso_m; idx++;
        end
        e_rv   = '0;
        e_err  = '0;
        e_miso = '0;
        if (rv_at >= 0)  e_rv[rv_at]   = 1'b1;
        if (err_at >= 0) e_err[err_at] = 1'b1;
        for (int m = 0; m < miso_len; m++) e_miso[miso_at + m] = s ? txd[m] : txd[DW-1-m];
        check({nm, " rx_valid trace"},  rv_tr,   e_rv);
        check({nm, " frame_err trace"}, err_tr,  e_err);
        check({nm, " MISO trace"},      miso_tr, e_miso);
        check({nm, " rx_data"},         64'(rx_m), 64'(rx_exp));
        check({nm, " busy in frame"},   64'(busy_low), 64'd1);
        check({nm, " busy after"},      64'(busy_m),   64'd0);
    endtask

    task automatic model_frame(input logic s, input logic [FW-1:0] fr, input int nb,
                               input int hold, input int tx_at, input logic [7:0] txd,
                               input string nm);
        int            rv_at, err_at, miso_at, miso_len;
        logic [FW-1:0] rx_exp;
        model(s, fr, nb, hold, tx_at, rv_at, err_at, miso_at, miso_len, rx_exp);
        run_frame(s, fr, nb, hold, tx_at, txd, rv_at, err_at, miso_at, miso_len, rx_exp, nm);
    endtask

    initial begin
        logic [FW-1:0] fr;
        int            nb, hold, tx_at, r;
        logic          s;

        // sel, frame, nbits, hold, tx_at, txd, rv_at, err_at, miso_at, miso_len, rx_exp
        tbl[0]  = '{1'b0, 10'h1FF, 10, 0,  -1, 8'h00, 9, -1, -1, 0, 10'h1FF};
        tbl[1]  = '{1'b0, 10'h205, 10, 0,  -1, 8'h00, 9, -1, -1, 0, 10'h205};
        tbl[2]  = '{1'b0, 10'h300, 10, 12, 2,  8'hA5, 9, -1, 12, 8, 10'h300};
        tbl[3]  = '{1'b0, 10'h3FF, 6,  0,  -1, 8'h00, -1, 6, -1, 0, 10'h300};
        tbl[4]  = '{1'b0, 10'h0AB, 10, 0,  -1, 8'h00, 9, -1, -1, 0, 10'h0AB};
        tbl[5]  = '{1'b0, 10'h300, 10, 0,  -1, 8'h00, -1, 9, -1, 0, 10'h0AB};
        tbl[6]  = '{1'b0, 10'h2AA, 10, 0,  -1, 8'h00, 9, -1, -1, 0, 10'h2AA};
        tbl[7]  = '{1'b0, 10'h3C0, 10, 20, -1, 8'h00, 9, 25, -1, 0, 10'h3C0};
        tbl[8]  = '{1'b0, 10'h311, 10, 5,  -1, 8'h00, 9, 15, -1, 0, 10'h311};
        tbl[9]  = '{1'b0, 10'h322, 10, 6,  0,  8'hFF, 9, 16, 10, 6, 10'h322};
        tbl[10] = '{1'b0, 10'h333, 10, 24, 15, 8'h3C, 9, -1, 25, 8, 10'h333};
        tbl[11] = '{1'b1, 10'h2C3, 10, 0,  -1, 8'h00, 9, -1, -1, 0, 10'h2C3};
        tbl[12] = '{1'b1, 10'h35A, 10, 10, 0,  8'h0F, 9, -1, 10, 8, 10'h35A};

        rst      = 1'b1;
        sel      = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #1;
        check("reset MISO",      64'({if0.MISO, if1.MISO}),           64'd0);
        check("reset rx_valid",  64'({if0.rx_valid, if1.rx_valid}),   64'd0);
        check("reset frame_err", 64'({if0.frame_err, if1.frame_err}), 64'd0);
        check("reset busy",      64'({if0.busy, if1.busy}),           64'd0);
        check("reset rx_data",   64'({if0.rx_data, if1.rx_data}),     64'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            run_frame(tbl[i].sel, tbl[i].frame, tbl[i].nbits, tbl[i].hold, tbl[i].tx_at,
                      tbl[i].txd, tbl[i].rv_at, tbl[i].err_at, tbl[i].miso_at,
                      tbl[i].miso_len, tbl[i].rx_exp, $sformatf("vec%0d", i));
        end

        // State left behind by the table.
        m_ok[0] = 1'b0; m_rx[0] = 10'h333;
        m_ok[1] = 1'b0; m_rx[1] = 10'h35A;

        // Reset in the middle of SEND.
        model_frame(1'b0, 10'h244, FW, 0, -1, 8'h00, "pre-reset rd addr");
        fr      = 10'h300;
        tx_data = 8'hFF;
        for (int b = 0; b < FW; b++) cyc(1'b0, fr[FW-1-b], 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("mid-send MISO", 64'(if0.MISO), 64'd1);
        rst = 1'b1;
        #1;
        check("rst MISO",      64'(if0.MISO),      64'd0);
        check("rst rx_valid",  64'(if0.rx_valid),  64'd0);
        check("rst busy",      64'(if0.busy),      64'd0);
        check("rst frame_err", 64'(if0.frame_err), 64'd0);
        check("rst rx_data",   64'(if0.rx_data),   64'd0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("rst held no err", 64'(if0.frame_err), 64'd0);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        m_ok[0] = 1'b0; m_rx[0] = '0;
        m_ok[1] = 1'b0; m_rx[1] = '0;
        model_frame(1'b0, 10'h355, FW, 4, 0, 8'h81, "post-reset rd data");

        // Randomised frames against the model.
        for (int k = 0; k < 40; k++) begin
            s = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 9);
            fr[FW-3:0]     = DW'($urandom);
            fr[FW-1:FW-2]  = (r < 2) ? 2'(r) : ((r < 5) ? 2'b10 : 2'b11);
            nb    = ($urandom_range(0, 99) < 15) ? $urandom_range(1, FW - 1) : FW;
            hold  = $urandom_range(0, 30);
            tx_at = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, hold);
            model_frame(s, fr, nb, hold, tx_at, 8'($urandom), $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
